// File: rtl/regfile_dump.sv
// Debug scan-out sequencer: walks an inclusive, modulo-8 register range through an
// asynchronous read port and streams (address, data) pairs out on a valid/ready port.
module regfile_dump #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Abort takes priority over a simultaneous handshake, so that pair is never counted.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          last_d    = last_reg;
          rd_addr_d = first_reg;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_data_d  = rd_data;
          out_addr_d  = rd_addr_q;
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_addr_q == last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q == FETCH) || (state_q == PRESENT);

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: expected pairs are queued at start time from a
// register-file array model and checked by an independent handshake monitor.
module tb_regfile_dump;

  logic       clk = 1'b0;
  logic       rst, start, abort, out_ready;
  logic [2:0] first_reg, last_reg, rd_addr, out_addr;
  logic [7:0] rd_data, out_data;
  logic       out_valid, busy, done;

  logic [7:0] regs [8];

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    bit         last;
  } pair_t;

  pair_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    hs_count = 0;
  bit    done_pending = 1'b0;

  always #5 clk = ~clk;

  // Register 0 always reads as zero in the modelled file.
  assign rd_data = (rd_addr == 3'd0) ? 8'h00 : regs[rd_addr];

  regfile_dump #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake happens at the coming edge when valid&ready and no abort/reset.
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev;
  logic [2:0] addr_prev;
  initial begin
    forever begin
      @(negedge clk);
      check("done_pulse", 32'(done), 32'(done_pending));
      done_pending = 1'b0;
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(data_prev));
        check("hold_addr", 32'(out_addr), 32'(addr_prev));
      end
      hold_prev = out_valid && !out_ready && !abort && !rst;
      data_prev = out_data;
      addr_prev = out_addr;
      if (out_valid && out_ready && !abort && !rst) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("[TB] FAIL unexpected_pair: got addr %0d data 0x%0h, none required", out_addr, out_data);
        end else begin
          pair_t p;
          p = exp_q.pop_front();
          check("pair_addr", 32'(out_addr), 32'(p.addr));
          check("pair_data", 32'(out_data), 32'(p.data));
          done_pending = p.last;
        end
      end
    end
  end

  task automatic queue_range(input logic [2:0] f, input logic [2:0] l);
    int n;
    n = ((int'(l) - int'(f) + 8) % 8) + 1;
    for (int i = 0; i < n; i++) begin
      pair_t p;
      p.addr = 3'((int'(f) + i) % 8);
      p.data = (p.addr == 3'd0) ? 8'h00 : regs[p.addr];
      p.last = (i == n - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic issue_start(input logic [2:0] f, input logic [2:0] l);
    queue_range(f, l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [2:0] l,
                               input int ready_pct, input bit poke);
    int n, cycles, hs0;
    bit got, poked;
    n = ((int'(l) - int'(f) + 8) % 8) + 1;
    hs0 = hs_count;
    cycles = 0;
    got = 1'b0;
    poked = 1'b0;
    issue_start(f, l);
    while (cycles < 400 && !got) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (poke && !poked && out_valid) begin
        start     = 1'b1;
        first_reg = f + 3'd3;
        last_reg  = l + 3'd5;
        poked     = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      cycles++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    if (ready_pct >= 100) check("dump_cycles", 32'(cycles), 32'(2 * n));
    check("handshakes", 32'(hs_count - hs0), 32'(n));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("busy_in_done", 32'(busy), 32'd0);
    exp_q.delete();
    step();
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
  endtask

  initial begin
    int k;
    bit hit;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_reg = 3'd0; last_reg = 3'd0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("reset");
    rst = 1'b0;
    step();
    check("idle_after_reset", 32'(busy), 32'd0);

    // Full dump 0..7 with ready held high.
    for (int i = 1; i < 8; i++) regs[i] = 8'(i * 8'h11);
    applyStimulus(3'd0, 3'd7, 100, 1'b0);

    // Wrapping range 6..1.
    regs[6] = 8'hA6; regs[7] = 8'hA7; regs[1] = 8'hA1;
    applyStimulus(3'd6, 3'd1, 100, 1'b0);

    // Backpressure with a register write while the pair is held.
    regs[3] = 8'h5C;
    out_ready = 1'b0;
    issue_start(3'd3, 3'd3);
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) regs[3] = 8'hFF;
      step();
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data", 32'(out_data), 32'h5C);
    check("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    k = 0;
    while (k < 10 && !done) begin step(); k++; end
    check("bp_done", 32'(done), 32'd1);
    check("bp_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    step();
    regs[3] = 8'h33;

    // Abort while entry 2 is presented with ready high.
    issue_start(3'd0, 3'd7);
    out_ready = 1'b1;
    k = 0; hit = 1'b0;
    while (k < 40 && !hit) begin
      if (out_valid && out_addr == 3'd2) hit = 1'b1;
      else begin step(); k++; end
    end
    check("abort_reached", 32'(hit), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_q.delete();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    step();
    check("abort_idle", 32'(busy), 32'd0);
    applyStimulus(3'd5, 3'd2, 100, 1'b0);

    // Reset during the fetch of entry 4, with a simultaneous start.
    issue_start(3'd0, 3'd7);
    out_ready = 1'b1;
    k = 0; hit = 1'b0;
    while (k < 40 && !hit) begin
      if (busy && !out_valid && rd_addr == 3'd4) hit = 1'b1;
      else begin step(); k++; end
    end
    check("fetch4_reached", 32'(hit), 32'd1);
    rst = 1'b1; start = 1'b1; first_reg = 3'd2; last_reg = 3'd5;
    step();
    rst = 1'b0; start = 1'b0;
    exp_q.delete();
    checkOutput("midrst");
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_idle", 32'(busy), 32'd0);
    end

    // Start pulsed while busy must not disturb the running range.
    applyStimulus(3'd1, 3'd4, 70, 1'b1);

    // Randomised dumps against the array model.
    for (int t = 0; t < 10; t++) begin
      for (int i = 1; i < 8; i++) regs[i] = 8'($urandom_range(255));
      applyStimulus(3'($urandom_range(7)), 3'($urandom_range(7)),
                    (t % 3 == 0) ? 100 : 60, 1'b0);
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
